// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared types and defaults for the data memory arbiter
package data_mem_arb_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} arb_state_t;
endpackage

// File: rtl/data_mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching from the index after last_gnt
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);
  always_comb begin
    idx = '0;
    // scan farthest-first so the nearest requester after last_gnt is the final assignment
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last_gnt) + k) % N_REQ]) idx = IW'((int'(last_gnt) + k) % N_REQ);
    gnt = |req ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of data_mem between requesters, one read outstanding
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          in_data_mem,
  output logic [ADDR_W-1:0]             adr_data,
  output logic                          write_data,
  output logic [ADDR_W-1:0]             adr_data_write,
  output logic [DATA_W-1:0]             data_write,
  input  logic [DATA_W-1:0]             data,
  input  logic                          out_data_mem
);
  localparam int IW = $clog2(N_REQ);
  arb_state_t state;
  logic [IW-1:0] last_gnt, owner, win;
  logic [N_REQ-1:0] arb_gnt;
  logic take;
  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req(req),
    .last_gnt(last_gnt),
    .gnt(arb_gnt),
    .idx(win)
  );
  assign take = !rst && state == IDLE && |arb_gnt;
  assign gnt = take ? arb_gnt : '0;
  assign rvalid = (!rst && state == RD_WAIT && out_data_mem) ? N_REQ'(1) << owner : '0;
  assign rdata = data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_gnt <= IW'(N_REQ - 1);
      owner <= '0;
      in_data_mem <= 1'b0;
      write_data <= 1'b0;
      adr_data <= '0;
      adr_data_write <= '0;
      data_write <= '0;
    end else begin
      in_data_mem <= 1'b0;
      write_data <= 1'b0;
      if (take) begin
        last_gnt <= win;
        if (we[win]) begin
          write_data <= 1'b1;
          adr_data_write <= addr[win];
          data_write <= wdata[win];
        end else begin
          in_data_mem <= 1'b1;
          adr_data <= addr[win];
          owner <= win;
          state <= RD_ISSUE;
        end
      end else if (state == RD_ISSUE) state <= RD_WAIT;
      else if (state == RD_WAIT && out_data_mem) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks against a memory model and reference model
module tb_data_mem_arbiter;
  localparam int N = 2;
  logic clk = 0, rst = 1;
  logic [N-1:0] req = '0, we = '0, gnt, rvalid;
  logic [N-1:0][4:0] addr = '0;
  logic [N-1:0][31:0] wdata = '0;
  logic [31:0] rdata, data_write, data = '0;
  logic in_data_mem, write_data, out_data_mem = 0;
  logic [4:0] adr_data, adr_data_write;
  logic [31:0] mem [0:31];
  logic [31:0] exp_mem [0:31];
  int tests = 0, fails = 0;

  data_mem_arbiter #(.N_REQ(N), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .in_data_mem(in_data_mem),
    .adr_data(adr_data), .write_data(write_data), .adr_data_write(adr_data_write),
    .data_write(data_write), .data(data), .out_data_mem(out_data_mem)
  );

  always #5 clk = ~clk;

  // data_mem: registered read with completion pulse, independent write port
  always @(posedge clk) begin
    out_data_mem <= in_data_mem;
    if (in_data_mem) data <= mem[adr_data];
    if (write_data) mem[adr_data_write] <= data_write;
  end

  task automatic do_reset();
    rst = 1; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 2'b11; we = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (gnt !== 2'b00 || rvalid !== 2'b00) begin
      fails++; $display("FAIL reset_gnt: gnt=%b rvalid=%b want 00 00", gnt, rvalid);
    end
    tests++;
    if ({in_data_mem, write_data, adr_data, adr_data_write, data_write} !== '0) begin
      fails++; $display("FAIL reset_outs: strobes=%b%b adr=%h wadr=%h wd=%h want all 0", in_data_mem, write_data, adr_data, adr_data_write, data_write);
    end
    @(posedge clk); #1 rst = 0; req = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    req = 2'b01; we = '0; addr[0] = 5'd2;
    @(negedge clk); tests++;
    if (gnt !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", gnt); end
    @(posedge clk); #1 req = '0;
    @(negedge clk); tests++;
    if (in_data_mem !== 1'b1 || adr_data !== 5'd2 || gnt !== 2'b00) begin
      fails++; $display("FAIL single_strobe: in=%b adr=%0d gnt=%b want 1 2 00", in_data_mem, adr_data, gnt);
    end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (rvalid !== 2'b01 || rdata !== 32'd3 || in_data_mem !== 1'b0) begin
      fails++; $display("FAIL single_rvalid: rvalid=%b rdata=%0d in=%b want 01 3 0", rvalid, rdata, in_data_mem);
    end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (rvalid !== 2'b00 || out_data_mem !== 1'b0 || in_data_mem !== 1'b0) begin
      fails++; $display("FAIL single_pulse_width: rvalid=%b out=%b in=%b want 00 0 0", rvalid, out_data_mem, in_data_mem);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int pw;
    logic [31:0] pd;
    do_reset();
    req = 2'b11; we = 2'b11; addr[0] = 5'd1; addr[1] = 5'd3;
    wdata[0] = $urandom; wdata[1] = $urandom;
    pw = 0; pd = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); tests++;
      if (gnt !== ((c % 2) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, (c % 2) ? 2'b10 : 2'b01);
      end
      if (c > 0) begin
        tests++;
        if (write_data !== 1'b1 || adr_data_write !== addr[pw] || data_write !== pd) begin
          fails++; $display("FAIL rr_write[%0d]: wr=%b adr=%0d d=%h want 1 %0d %h", c, write_data, adr_data_write, data_write, addr[pw], pd);
        end
      end
      pw = c % 2; pd = wdata[pw]; exp_mem[addr[pw]] = pd;
      @(posedge clk); #1 wdata[pw] = $urandom;
    end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    logic found;
    do_reset();
    req = 2'b01; we = '0; addr[0] = 5'd4;
    @(negedge clk); tests++;
    if (gnt !== 2'b01) begin fails++; $display("FAIL coll_gnt0: got %b want 01", gnt); end
    @(posedge clk); #1 req = 2'b10; we[1] = 1'b1; addr[1] = 5'd5; wdata[1] = 32'h1234_5678;
    @(negedge clk); tests++;
    if (gnt !== 2'b00) begin fails++; $display("FAIL coll_block1: got %b want 00", gnt); end
    @(posedge clk); #1;
    @(negedge clk); tests++;
    if (gnt !== 2'b00 || rvalid !== 2'b01 || rdata !== 32'd10) begin
      fails++; $display("FAIL coll_rvalid: gnt=%b rvalid=%b rdata=%0d want 00 01 10", gnt, rvalid, rdata);
    end
    found = 0;
    for (int n = 0; n < 6 && !found; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (gnt === 2'b10) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL coll_gnt1: got %b want 10 within 6 cycles", gnt); end
    exp_mem[5] = 32'h1234_5678;
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_after_write();
    logic found;
    logic [31:0] got;
    do_reset();
    req = 2'b01; we = 2'b01; addr[0] = 5'd7; wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk); tests++;
    if (gnt !== 2'b01) begin fails++; $display("FAIL raw_wgnt: got %b want 01", gnt); end
    @(posedge clk); #1 we = '0;
    @(negedge clk); tests++;
    if (gnt !== 2'b01 || write_data !== 1'b1) begin
      fails++; $display("FAIL raw_rgnt: gnt=%b wr=%b want 01 1", gnt, write_data);
    end
    exp_mem[7] = 32'hDEAD_BEEF;
    @(posedge clk); #1 req = '0;
    found = 0; got = '0;
    for (int n = 0; n < 6 && !found; n++) begin
      @(negedge clk);
      if (rvalid === 2'b01) begin found = 1; got = rdata; end
      @(posedge clk); #1;
    end
    tests++;
    if (!found || got !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL raw_data: seen=%b rdata=%h want 1 deadbeef", found, got);
    end
  endtask

  task automatic test_reset_mid_read();
    logic rv_seen, outs_bad;
    do_reset();
    req = 2'b01; we = '0; addr[0] = 5'd3;
    @(negedge clk); tests++;
    if (gnt !== 2'b01) begin fails++; $display("FAIL midrst_gnt: got %b want 01", gnt); end
    @(posedge clk); #1 req = '0; rst = 1;
    @(negedge clk); tests++;
    if (in_data_mem !== 1'b1 || rvalid !== 2'b00) begin
      fails++; $display("FAIL midrst_strobe: in=%b rvalid=%b want 1 00", in_data_mem, rvalid);
    end
    @(posedge clk); #1 rst = 0;
    rv_seen = 0; outs_bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rvalid !== 2'b00) rv_seen = 1;
      if ({in_data_mem, write_data, adr_data, adr_data_write, data_write} !== '0) outs_bad = 1;
      @(posedge clk); #1;
    end
    tests++;
    if (rv_seen) begin fails++; $display("FAIL midrst_rvalid: got rvalid pulse want none"); end
    tests++;
    if (outs_bad) begin fails++; $display("FAIL midrst_outs: got nonzero memory outputs want all 0"); end
    req = 2'b11; we = '0; addr[0] = 5'd1; addr[1] = 5'd2;
    @(negedge clk); tests++;
    if (gnt !== 2'b01) begin fails++; $display("FAIL midrst_prio: got %b want 01", gnt); end
    @(posedge clk); #1 req = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int cycles);
    int last, blocked, w;
    logic exp_wr, exp_rd, exp_rv;
    logic [4:0] ea_w, ea_r;
    logic [31:0] ed_w, ed_r;
    logic [N-1:0] eg, rd_own, rv_own;
    do_reset();
    last = N - 1; blocked = 0;
    exp_wr = 0; exp_rd = 0; exp_rv = 0;
    ea_w = '0; ea_r = '0; ed_w = '0; ed_r = '0; rd_own = '0; rv_own = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1; we[i] = 1'($urandom_range(0, 1));
          addr[i] = 5'($urandom_range(0, 7)); wdata[i] = $urandom;
        end else if (req[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
      end
      eg = '0; w = -1;
      if (blocked == 0)
        for (int k = 1; k <= N; k++) if (w < 0 && req[(last + k) % N]) w = (last + k) % N;
      if (w >= 0) eg[w] = 1'b1;
      @(negedge clk);
      tests++;
      if (gnt !== eg) begin fails++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, eg); end
      tests++;
      if (write_data !== exp_wr || (exp_wr && (adr_data_write !== ea_w || data_write !== ed_w))) begin
        fails++; $display("FAIL rand_write[%0d]: wr=%b adr=%0d d=%h want %b %0d %h", c, write_data, adr_data_write, data_write, exp_wr, ea_w, ed_w);
      end
      tests++;
      if (in_data_mem !== exp_rd || (exp_rd && adr_data !== ea_r)) begin
        fails++; $display("FAIL rand_strobe[%0d]: in=%b adr=%0d want %b %0d", c, in_data_mem, adr_data, exp_rd, ea_r);
      end
      tests++;
      if (rvalid !== (exp_rv ? rv_own : '0) || out_data_mem !== exp_rv || (exp_rv && rdata !== ed_r)) begin
        fails++; $display("FAIL rand_rvalid[%0d]: rvalid=%b out=%b rdata=%h want %b %b %h", c, rvalid, out_data_mem, rdata, exp_rv ? rv_own : '0, exp_rv, ed_r);
      end
      exp_rv = exp_rd; rv_own = rd_own;
      exp_wr = 0; exp_rd = 0;
      if (blocked > 0) blocked--;
      if (w >= 0) begin
        last = w;
        if (we[w]) begin
          exp_wr = 1; ea_w = addr[w]; ed_w = wdata[w]; exp_mem[addr[w]] = wdata[w];
        end else begin
          exp_rd = 1; ea_r = addr[w]; ed_r = exp_mem[addr[w]]; rd_own = eg; blocked = 2;
        end
      end
      @(posedge clk); #1;
      if (w >= 0) req[w] = 1'b0;
    end
    req = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'(i * 3 + 100);
      exp_mem[i] = 32'(i * 3 + 100);
    end
    mem[2] = 32'd3; exp_mem[2] = 32'd3;
    mem[4] = 32'd10; exp_mem[4] = 32'd10;
    test_reset();
    test_single_read();
    test_round_robin();
    test_collision();
    test_read_after_write();
    test_reset_mid_read();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
